// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Byte-addressed instruction memory with a one-deep fetch stage. Each issued
// fetch reads four consecutive bytes at the word-aligned pc. It presents them
// one cycle later as a 32-bit word with a valid/ready handshake toward the
// consumer.
//
// Ports
//   clk             single clock, all state on rising edge
//   reset           synchronous active-high reset
//   load_en         write load_data into mem[load_addr] this cycle
//   load_addr       byte address for load
//   load_data       byte written
//   fetch_en        permits sequential fetch
//   redirect_valid  branch/jump redirect request (flushes held word)
//   redirect_pc     redirect target byte address (low two bits dropped)
//   instr_ready     consumer accepts instr this cycle
//   instr_valid     instr/instr_pc hold a valid fetched word
//   instr           fetched instruction word
//   instr_pc        byte address of instr
//   misaligned_err  sticky: a redirect with nonzero low bits was seen
//   fetch_count     accepted instructions (valid && ready), wrapping
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned RESET_PC   = 0,
   parameter bit          BIG_ENDIAN = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              instr_ready,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              misaligned_err,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam int unsigned       DEPTH      = 1 << ADDR_W;
   // Force word alignment even if a misaligned RESET_PC is supplied.
   localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC & 32'hFFFF_FFFC);

   logic [7:0]        mem_q [DEPTH];

   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic              vld_q,   vld_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q,   ipc_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [3:0][7:0]   rd_bytes;
   logic [31:0]       rd_word;
   logic              hs;
   logic              issue;

   // Memory is never reset; loads are ignored while reset is asserted.
   always_ff @(posedge clk) begin
      if (!reset && load_en) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Four byte lanes at pc..pc+3; the address add wraps naturally at ADDR_W.
   always_comb begin
      for (int b = 0; b < 4; b++) begin
         rd_bytes[b] = mem_q[pc_q + ADDR_W'(b)];
      end
   end

   assign rd_word = BIG_ENDIAN ? {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]}
                               : {rd_bytes[3], rd_bytes[2], rd_bytes[1], rd_bytes[0]};

   assign hs    = vld_q && instr_ready;
   // A load in the same cycle blocks issue so a fetch never races a write.
   assign issue = fetch_en && !load_en && !redirect_valid && (!vld_q || instr_ready);

   always_comb begin
      pc_d    = pc_q;
      vld_d   = vld_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      err_d   = err_q;
      // Handshakes count even when a redirect flushes in the same cycle.
      cnt_d   = cnt_q + CNT_W'(hs);

      if (redirect_valid) begin
         vld_d = 1'b0;
         pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
         if (redirect_pc[1:0] != 2'b00) begin
            err_d = 1'b1;
         end
      end else if (issue) begin
         vld_d   = 1'b1;
         instr_d = rd_word;
         ipc_d   = pc_q;
         pc_d    = pc_q + ADDR_W'(4);
      end else if (hs) begin
         vld_d = 1'b0;
      end
      // Otherwise (stall or idle) everything holds.
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC_A;
         vld_q   <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_valid    = vld_q;
   assign instr          = instr_q;
   assign instr_pc       = ipc_q;
   assign misaligned_err = err_q;
   assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a big-endian and a little-endian instance share
// all inputs. A queue scoreboard predicts each fetched word at issue time.
// A vector table plus hand sequences pin explicit expected values.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, load_en, fetch_en, redirect_valid, instr_ready;
   logic [7:0]  load_addr, load_data, redirect_pc;
   logic        instr_valid, misaligned_err;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic [15:0] fetch_count;
   logic        v2, err2;
   logic [31:0] instr2;
   logic [7:0]  ipc2;
   logic [15:0] cnt2;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0), .BIG_ENDIAN(1'b1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_ready(instr_ready), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .misaligned_err(misaligned_err),
      .fetch_count(fetch_count));

   instr_fetch_unit #(.ADDR_W(8), .RESET_PC(0), .BIG_ENDIAN(1'b0), .CNT_W(16)) dut_le (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_ready(instr_ready), .instr_valid(v2),
      .instr(instr2), .instr_pc(ipc2), .misaligned_err(err2),
      .fetch_count(cnt2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   // ---- reference model ----
   typedef struct {
      logic [7:0]  pc;
      logic [31:0] be;
      logic [31:0] le;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  tmem [256];
   logic [7:0]  m_pc;
   logic        m_err;
   logic [15:0] m_cnt;

   function automatic logic [31:0] word_be(input logic [7:0] a);
      return {tmem[a], tmem[a + 8'd1], tmem[a + 8'd2], tmem[a + 8'd3]};
   endfunction

   function automatic logic [31:0] word_le(input logic [7:0] a);
      return {tmem[a + 8'd3], tmem[a + 8'd2], tmem[a + 8'd1], tmem[a]};
   endfunction

   // One clock: drive inputs, step the model, check outputs 1 time unit after the edge.
   task automatic cyc(input logic rst, input logic fe, input logic rdy, input logic rv,
                      input logic [7:0] rpc, input logic le, input logic [7:0] la,
                      input logic [7:0] ld);
      logic hs, iss;
      exp_t e;
      reset = rst; fetch_en = fe; instr_ready = rdy; redirect_valid = rv;
      redirect_pc = rpc; load_en = le; load_addr = la; load_data = ld;
      hs = (sbq.size() > 0) && rdy;
      if (rst) begin
         sbq.delete(); m_pc = 8'd0; m_err = 1'b0; m_cnt = 16'd0;
      end else begin
         if (hs) m_cnt++;
         if (rv) begin
            sbq.delete();
            m_pc = {rpc[7:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_err = 1'b1;
         end else begin
            iss = fe && !le && (sbq.size() == 0 || rdy);
            if (hs) void'(sbq.pop_front());
            if (iss) begin
               e.pc = m_pc; e.be = word_be(m_pc); e.le = word_le(m_pc);
               sbq.push_back(e);
               m_pc = m_pc + 8'd4;
            end
         end
         if (le) tmem[la] = ld;
      end
      @(posedge clk);
      #1;
      chk("sb_valid", 32'(instr_valid), 32'(sbq.size() > 0));
      if (sbq.size() > 0) begin
         chk("sb_instr_pc", 32'(instr_pc), 32'(sbq[0].pc));
         chk("sb_instr_be", instr, sbq[0].be);
         chk("sb_instr_le", instr2, sbq[0].le);
      end
      chk("sb_err", 32'(misaligned_err), 32'(m_err));
      chk("sb_count", 32'(fetch_count), 32'(m_cnt));
   endtask

   // ---- directed vectors with hand-derived expectations ----
   typedef struct {
      logic        fe, rdy, rv;
      logic [7:0]  rpc;
      logic        ev;
      logic [7:0]  eipc;
      logic        eerr;
      logic [15:0] ecnt;
      logic        ci;
      logic [31:0] ei;
   } vec_t;

   function automatic vec_t mk(input int fe, input int rdy, input int rv, input int rpc,
                               input int ev, input int eipc, input int eerr, input int ecnt,
                               input int ci = 0, input logic [31:0] ei = 32'h0);
      vec_t v;
      v.fe = 1'(fe); v.rdy = 1'(rdy); v.rv = 1'(rv); v.rpc = 8'(rpc);
      v.ev = 1'(ev); v.eipc = 8'(eipc); v.eerr = 1'(eerr); v.ecnt = 16'(ecnt);
      v.ci = 1'(ci); v.ei = ei;
      return v;
   endfunction

   vec_t tbl[21];

   initial begin
      for (int i = 0; i < 256; i++) tmem[i] = 8'h00;
      m_pc = 8'd0; m_err = 1'b0; m_cnt = 16'd0;

      //             fe rdy rv rpc  ev ipc err cnt
      tbl[0]  = mk(1, 1, 0, 0,   1, 0,   0, 0, 1, 32'h200a000a);
      tbl[1]  = mk(1, 1, 0, 0,   1, 4,   0, 1);
      tbl[2]  = mk(1, 0, 0, 0,   1, 4,   0, 1);  // five-cycle stall
      tbl[3]  = mk(1, 0, 0, 0,   1, 4,   0, 1);
      tbl[4]  = mk(1, 0, 0, 0,   1, 4,   0, 1);
      tbl[5]  = mk(1, 0, 0, 0,   1, 4,   0, 1);
      tbl[6]  = mk(1, 0, 0, 0,   1, 4,   0, 1);
      tbl[7]  = mk(1, 1, 0, 0,   1, 8,   0, 2);
      tbl[8]  = mk(1, 1, 0, 0,   1, 12,  0, 3);
      tbl[9]  = mk(0, 1, 0, 0,   0, 0,   0, 4);
      tbl[10] = mk(0, 1, 0, 0,   0, 0,   0, 4);
      tbl[11] = mk(1, 0, 0, 0,   1, 16,  0, 4);
      tbl[12] = mk(0, 0, 0, 0,   1, 16,  0, 4);  // fetch_en low keeps held word
      tbl[13] = mk(1, 0, 1, 6,   0, 0,   1, 4);  // misaligned redirect flushes
      tbl[14] = mk(1, 1, 0, 0,   1, 4,   1, 4);
      tbl[15] = mk(1, 1, 1, 252, 0, 0,   1, 5);  // handshake with redirect counts
      tbl[16] = mk(1, 1, 0, 0,   1, 252, 1, 5, 1, 32'hAABBCCDD);
      tbl[17] = mk(1, 1, 0, 0,   1, 0,   1, 6);  // pc wraps 252 -> 0
      tbl[18] = mk(1, 1, 1, 100, 0, 0,   1, 7);
      tbl[19] = mk(1, 0, 0, 0,   1, 100, 1, 7, 1, 32'h11223344);
      tbl[20] = mk(0, 1, 0, 0,   0, 0,   1, 8);

      // Reset state
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", 32'(instr_pc), 32'h0);
      chk("rst_err", 32'(misaligned_err), 32'h0);
      chk("rst_cnt", 32'(fetch_count), 32'h0);

      // Program load
      cyc(0, 0, 0, 0, 0, 1, 8'd0, 8'h20);
      cyc(0, 0, 0, 0, 0, 1, 8'd1, 8'h0a);
      cyc(0, 0, 0, 0, 0, 1, 8'd2, 8'h00);
      cyc(0, 0, 0, 0, 0, 1, 8'd3, 8'h0a);
      for (int a = 4; a < 32; a++) cyc(0, 0, 0, 0, 0, 1, 8'(a), 8'(a * 3 + 1));
      cyc(0, 0, 0, 0, 0, 1, 8'd100, 8'h11);
      cyc(0, 0, 0, 0, 0, 1, 8'd101, 8'h22);
      cyc(0, 0, 0, 0, 0, 1, 8'd102, 8'h33);
      cyc(0, 0, 0, 0, 0, 1, 8'd103, 8'h44);
      cyc(0, 0, 0, 0, 0, 1, 8'd252, 8'hAA);
      cyc(0, 0, 0, 0, 0, 1, 8'd253, 8'hBB);
      cyc(0, 0, 0, 0, 0, 1, 8'd254, 8'hCC);
      cyc(0, 0, 0, 0, 0, 1, 8'd255, 8'hDD);
      // Load during reset must be ignored (checked when 100 is fetched)
      cyc(1, 0, 0, 0, 0, 1, 8'd100, 8'h55);

      for (int i = 0; i < 21; i++) begin
         cyc(1'b0, tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, 1'b0, 8'd0, 8'd0);
         chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("v%0d_pc", i), 32'(instr_pc), 32'(tbl[i].eipc));
         chk($sformatf("v%0d_err", i), 32'(misaligned_err), 32'(tbl[i].eerr));
         chk($sformatf("v%0d_cnt", i), 32'(fetch_count), 32'(tbl[i].ecnt));
         if (tbl[i].ci) chk($sformatf("v%0d_instr", i), instr, tbl[i].ei);
         if (i == 0) chk("le_instr", instr2, 32'h0a000a20);
      end

      // Held word is not refreshed by a load to its own address
      cyc(0, 1, 1, 1, 8'd0, 0, 0, 0);
      cyc(0, 1, 0, 0, 8'd0, 0, 0, 0);
      cyc(0, 1, 0, 0, 8'd0, 1, 8'd1, 8'hFF);
      chk("hold_vs_load", instr, 32'h200a000a);
      // Load blocks issue even while the consumer accepts
      cyc(0, 1, 1, 0, 8'd0, 1, 8'd1, 8'h0a);
      chk("load_blocks_issue", 32'(instr_valid), 32'h0);
      chk("load_cnt", 32'(fetch_count), 32'd9);
      // Load and redirect in the same cycle both take effect
      cyc(0, 1, 1, 1, 8'd0, 1, 8'd3, 8'h0b);
      cyc(0, 1, 0, 0, 8'd0, 0, 0, 0);
      chk("load_redirect", instr, 32'h200a000b);
      cyc(0, 1, 0, 0, 8'd0, 1, 8'd3, 8'h0a);

      // Mid-stream reset with a held word
      chk("pre_rst_valid", 32'(instr_valid), 32'h1);
      cyc(1, 1, 0, 0, 8'd0, 0, 0, 0);
      chk("mid_rst_valid", 32'(instr_valid), 32'h0);
      chk("mid_rst_instr", instr, 32'h0);
      chk("mid_rst_pc", 32'(instr_pc), 32'h0);
      chk("mid_rst_err", 32'(misaligned_err), 32'h0);
      chk("mid_rst_cnt", 32'(fetch_count), 32'h0);
      cyc(0, 1, 1, 0, 8'd0, 0, 0, 0);
      chk("post_rst_pc", 32'(instr_pc), 32'h0);
      chk("post_rst_instr", instr, 32'h200a000a);
      cyc(0, 0, 1, 0, 8'd0, 0, 0, 0);
      chk("post_rst_cnt", 32'(fetch_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
